// File: rtl/counter_trigger_pkg.sv
// Shared definitions for counter_trigger_gen.
// Contents:
//   ctg_state_e            - FSM state; the encoding is visible on state_sts
//   DEFAULT_COUNT_WIDTH    - default width of reference value and tick counter
//   DEFAULT_PRESCALE_WIDTH - default width of the optional tick divider
package counter_trigger_pkg;

    typedef enum logic [1:0] {
        BYPASS   = 2'd0,
        IDLE     = 2'd1,
        COUNTING = 2'd2,
        FIRED    = 2'd3
    } ctg_state_e;

    localparam int DEFAULT_COUNT_WIDTH    = 32;
    localparam int DEFAULT_PRESCALE_WIDTH = 16;

endpackage

// File: rtl/counter_trigger_gen_if.sv
// Configuration, tick and status bundle of counter_trigger_gen.
// Optional feature macro: COUNTER_TRIGGER_PRESCALE_EN adds cfg_tick_divider.
// Signals:
//   cfg_enable        0: bypass, trigger forced high; 1: active
//   cfg_arm           rising edge starts a count, low level disarms
//   cfg_reference     counted ticks required before firing
//   cfg_tick_divider  count one tick every (value+1) sample ticks (macro only)
//   sample_tick       single-cycle sample strobe
//   counter_trigger   trigger level to the reset manager
//   count_sts         current counter value
//   state_sts         current FSM state encoding
// Modports: master drives configuration/ticks, slave is the generator.
interface counter_trigger_gen_if #(
    parameter int COUNT_WIDTH    = 32,
    parameter int PRESCALE_WIDTH = 16
);
    logic                   cfg_enable;
    logic                   cfg_arm;
    logic [COUNT_WIDTH-1:0] cfg_reference;
`ifdef COUNTER_TRIGGER_PRESCALE_EN
    logic [PRESCALE_WIDTH-1:0] cfg_tick_divider;
`endif
    logic                   sample_tick;
    logic                   counter_trigger;
    logic [COUNT_WIDTH-1:0] count_sts;
    logic [1:0]             state_sts;

`ifdef COUNTER_TRIGGER_PRESCALE_EN
    modport master (
        output cfg_enable, cfg_arm, cfg_reference, cfg_tick_divider, sample_tick,
        input  counter_trigger, count_sts, state_sts
    );
    modport slave (
        input  cfg_enable, cfg_arm, cfg_reference, cfg_tick_divider, sample_tick,
        output counter_trigger, count_sts, state_sts
    );
`else
    modport master (
        output cfg_enable, cfg_arm, cfg_reference, sample_tick,
        input  counter_trigger, count_sts, state_sts
    );
    modport slave (
        input  cfg_enable, cfg_arm, cfg_reference, sample_tick,
        output counter_trigger, count_sts, state_sts
    );
`endif
endinterface

// File: rtl/counter_trigger_gen_tick_prescaler.sv
// tick_prescaler: divides sample_tick so that every (divider+1)-th tick is
// reported as qualified. Used by counter_trigger_gen only when
// COUNTER_TRIGGER_PRESCALE_EN is defined.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   clear           restarts the divider (arm edge or disable)
//   sample_tick     raw tick strobe
//   divider         tick divider value
//   qualified_tick  combinational strobe for the counting FSM
module tick_prescaler #(
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      sample_tick,
    input  logic [PRESCALE_WIDTH-1:0] divider,
    output logic                      qualified_tick
);
    logic [PRESCALE_WIDTH-1:0] count;
    logic                      at_limit;

    // >= so a divider lowered below the running count still qualifies
    // on the next tick instead of running around the full range.
    assign at_limit       = (count >= divider);
    assign qualified_tick = sample_tick && !clear && at_limit;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (sample_tick) begin
            count <= at_limit ? '0 : count + 1'b1;
        end
    end
endmodule

// File: rtl/counter_trigger_gen.sv
// counter_trigger_gen: produces the counter_trigger level for the reset
// manager internal-trigger path. High while disabled (bypass); when enabled
// and armed it stays low until cfg_reference qualified ticks have been
// counted, then latches high until the arm is dropped.
// Optional feature macro: COUNTER_TRIGGER_PRESCALE_EN (tick prescaler and
// cfg_tick_divider).
// Ports:
//   clk               system clock
//   peripheral_reset  synchronous active-high reset
//   bus               counter_trigger_gen_if slave (config, ticks, status)
module counter_trigger_gen
    import counter_trigger_pkg::*;
#(
    parameter int COUNT_WIDTH    = DEFAULT_COUNT_WIDTH,
    parameter int PRESCALE_WIDTH = DEFAULT_PRESCALE_WIDTH
) (
    input  logic                  clk,
    input  logic                  peripheral_reset,
    counter_trigger_gen_if.slave  bus
);
    ctg_state_e             state, state_nxt;
    logic [COUNT_WIDTH-1:0] count, count_nxt, count_inc;
    logic                   trig;
    logic                   arm_q;
    logic                   arm_rise;
    logic                   qtick;

    assign arm_rise  = bus.cfg_arm && !arm_q;
    assign count_inc = (count == '1) ? count : count + 1'b1;

`ifdef COUNTER_TRIGGER_PRESCALE_EN
    tick_prescaler #(
        .PRESCALE_WIDTH (PRESCALE_WIDTH)
    ) u_tick_prescaler (
        .clk            (clk),
        .rst            (peripheral_reset),
        .clear          (arm_rise || !bus.cfg_enable),
        .sample_tick    (bus.sample_tick),
        .divider        (bus.cfg_tick_divider),
        .qualified_tick (qtick)
    );
`else
    assign qtick = bus.sample_tick;
`endif

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        if (!bus.cfg_enable) begin
            state_nxt = BYPASS;
            count_nxt = '0;
        end else begin
            case (state)
                BYPASS: state_nxt = IDLE;
                IDLE: begin
                    if (arm_rise) begin
                        state_nxt = COUNTING;
                        count_nxt = '0;
                    end
                end
                COUNTING: begin
                    if (!bus.cfg_arm) begin
                        state_nxt = IDLE;
                        count_nxt = '0;
                    end else if (bus.cfg_reference == '0) begin
                        state_nxt = FIRED;
                    end else if (qtick) begin
                        count_nxt = count_inc;
                        // A saturated counter no longer advances, so it can
                        // never newly match a reference.
                        if (count != '1 && count_inc == bus.cfg_reference) begin
                            state_nxt = FIRED;
                        end
                    end
                end
                FIRED: begin
                    if (!bus.cfg_arm) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = BYPASS;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (peripheral_reset) begin
            state <= BYPASS;
            count <= '0;
            trig  <= 1'b1;
            arm_q <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            trig  <= (state_nxt == BYPASS) || (state_nxt == FIRED);
            arm_q <= bus.cfg_arm;
        end
    end

    assign bus.counter_trigger = trig;
    assign bus.count_sts       = count;
    assign bus.state_sts       = state;
endmodule

// File: tb/tb_counter_trigger_gen.sv
module tb_counter_trigger_gen;
    localparam int CW = 8;
    localparam int PW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    counter_trigger_gen_if #(.COUNT_WIDTH(CW), .PRESCALE_WIDTH(PW)) bus ();

    counter_trigger_gen #(
        .COUNT_WIDTH    (CW),
        .PRESCALE_WIDTH (PW)
    ) dut (
        .clk              (clk),
        .peripheral_reset (rst),
        .bus              (bus.slave)
    );

    // Observed vector: {counter_trigger, state_sts[1:0], count_sts[7:0]}
    logic [10:0] obs;
    assign obs = {bus.counter_trigger, bus.state_sts, bus.count_sts};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.sample_tick = i[0];
            step();
            checks++;
            if (obs !== {1'b1, 2'd0, 8'd0}) begin
                failures++;
                $display("FAIL reset_state got=%h exp=%h", obs, {1'b1, 2'd0, 8'd0});
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_bypass();
        for (int i = 0; i < 6; i++) begin
            bus.sample_tick = ~i[0];
            step();
            checks++;
            if (obs !== {1'b1, 2'd0, 8'd0}) begin
                failures++;
                $display("FAIL bypass_ticks cyc=%0d got=%h exp=%h", i, obs, {1'b1, 2'd0, 8'd0});
            end
        end
        bus.sample_tick = 1'b0;
    endtask

    task automatic test_count_fire();
        logic [10:0] exp;
        bus.cfg_reference = 8'd5;
        bus.cfg_enable = 1'b1;
        step();
        checks++;
        if (obs !== {1'b0, 2'd1, 8'd0}) begin
            failures++;
            $display("FAIL enable_idle got=%h exp=%h", obs, {1'b0, 2'd1, 8'd0});
        end
        bus.cfg_arm = 1'b1;
        step();
        checks++;
        if (obs !== {1'b0, 2'd2, 8'd0}) begin
            failures++;
            $display("FAIL arm_counting got=%h exp=%h", obs, {1'b0, 2'd2, 8'd0});
        end
        for (int i = 1; i <= 5; i++) begin
            bus.sample_tick = 1'b1;
            step();
            bus.sample_tick = 1'b0;
            exp = (i == 5) ? {1'b1, 2'd3, 8'd5} : {1'b0, 2'd2, 8'(i)};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL count_tick%0d got=%h exp=%h", i, obs, exp);
            end
            for (int g = 0; g < 2; g++) begin
                step();
                checks++;
                if (obs !== exp) begin
                    failures++;
                    $display("FAIL count_gap%0d got=%h exp=%h", i, obs, exp);
                end
            end
        end
        bus.cfg_arm = 1'b0;
        step();
        checks++;
        if (obs[10:8] !== {1'b0, 2'd1}) begin
            failures++;
            $display("FAIL fired_disarm got=%h exp=%h", obs[10:8], {1'b0, 2'd1});
        end
    endtask

    task automatic test_ref_zero();
        bus.cfg_reference = 8'd0;
        bus.cfg_arm = 1'b1;
        step();
        checks++;
        if (obs !== {1'b0, 2'd2, 8'd0}) begin
            failures++;
            $display("FAIL ref0_cyc1 got=%h exp=%h", obs, {1'b0, 2'd2, 8'd0});
        end
        step();
        checks++;
        if (obs !== {1'b1, 2'd3, 8'd0}) begin
            failures++;
            $display("FAIL ref0_fire got=%h exp=%h", obs, {1'b1, 2'd3, 8'd0});
        end
        bus.cfg_arm = 1'b0;
        step();
    endtask

    task automatic test_arm_with_tick();
        bus.cfg_reference = 8'd1;
        bus.cfg_arm = 1'b1;
        bus.sample_tick = 1'b1;
        step();
        bus.sample_tick = 1'b0;
        checks++;
        if (obs !== {1'b0, 2'd2, 8'd0}) begin
            failures++;
            $display("FAIL edge_tick_ignored got=%h exp=%h", obs, {1'b0, 2'd2, 8'd0});
        end
        step();
        bus.sample_tick = 1'b1;
        step();
        bus.sample_tick = 1'b0;
        checks++;
        if (obs !== {1'b1, 2'd3, 8'd1}) begin
            failures++;
            $display("FAIL edge_tick_fire got=%h exp=%h", obs, {1'b1, 2'd3, 8'd1});
        end
        bus.cfg_arm = 1'b0;
        step();
    endtask

    task automatic test_arm_drop();
        bus.cfg_reference = 8'd10;
        bus.cfg_arm = 1'b1;
        step();
        for (int i = 1; i <= 3; i++) begin
            bus.sample_tick = 1'b1;
            step();
            bus.sample_tick = 1'b0;
            step();
        end
        checks++;
        if (obs !== {1'b0, 2'd2, 8'd3}) begin
            failures++;
            $display("FAIL drop_count3 got=%h exp=%h", obs, {1'b0, 2'd2, 8'd3});
        end
        bus.cfg_arm = 1'b0;
        step();
        checks++;
        if (obs !== {1'b0, 2'd1, 8'd0}) begin
            failures++;
            $display("FAIL drop_idle got=%h exp=%h", obs, {1'b0, 2'd1, 8'd0});
        end
    endtask

    task automatic test_disable();
        bus.cfg_reference = 8'd20;
        bus.cfg_arm = 1'b1;
        step();
        for (int i = 0; i < 7; i++) begin
            bus.sample_tick = 1'b1;
            step();
            bus.sample_tick = 1'b0;
        end
        checks++;
        if (obs !== {1'b0, 2'd2, 8'd7}) begin
            failures++;
            $display("FAIL dis_count7 got=%h exp=%h", obs, {1'b0, 2'd2, 8'd7});
        end
        bus.cfg_enable = 1'b0;
        step();
        checks++;
        if (obs !== {1'b1, 2'd0, 8'd0}) begin
            failures++;
            $display("FAIL dis_bypass got=%h exp=%h", obs, {1'b1, 2'd0, 8'd0});
        end
        bus.cfg_enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.sample_tick = i[0];
            step();
            checks++;
            if (obs !== {1'b0, 2'd1, 8'd0}) begin
                failures++;
                $display("FAIL reen_held_arm cyc=%0d got=%h exp=%h", i, obs, {1'b0, 2'd1, 8'd0});
            end
        end
        bus.sample_tick = 1'b0;
        bus.cfg_arm = 1'b0;
        step();
        bus.cfg_arm = 1'b1;
        step();
        checks++;
        if (obs !== {1'b0, 2'd2, 8'd0}) begin
            failures++;
            $display("FAIL rearm_edge got=%h exp=%h", obs, {1'b0, 2'd2, 8'd0});
        end
        bus.cfg_arm = 1'b0;
        step();
    endtask

    task automatic test_saturation();
        bus.cfg_reference = 8'd200;
        bus.cfg_arm = 1'b1;
        step();
        bus.sample_tick = 1'b1;
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (obs !== {1'b0, 2'd2, 8'd5}) begin
            failures++;
            $display("FAIL sat_count5 got=%h exp=%h", obs, {1'b0, 2'd2, 8'd5});
        end
        // Reference moved below the running count: must saturate, never wrap to it.
        bus.cfg_reference = 8'd3;
        for (int i = 0; i < 260; i++) step();
        checks++;
        if (obs !== {1'b0, 2'd2, 8'd255}) begin
            failures++;
            $display("FAIL sat_hold got=%h exp=%h", obs, {1'b0, 2'd2, 8'd255});
        end
        bus.sample_tick = 1'b0;
        bus.cfg_arm = 1'b0;
        step();
    endtask

`ifdef COUNTER_TRIGGER_PRESCALE_EN
    task automatic test_prescale();
        logic [10:0] exp;
        bus.cfg_tick_divider = 4'd2;
        bus.cfg_reference = 8'd2;
        bus.cfg_arm = 1'b1;
        step();
        for (int k = 1; k <= 6; k++) begin
            bus.sample_tick = 1'b1;
            step();
            bus.sample_tick = 1'b0;
            exp = (k == 6) ? {1'b1, 2'd3, 8'd2} : {1'b0, 2'd2, 8'(k / 3)};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL presc_tick%0d got=%h exp=%h", k, obs, exp);
            end
            step();
        end
        bus.cfg_arm = 1'b0;
        step();
        bus.cfg_tick_divider = 4'd0;
    endtask
`endif

    task automatic test_reset_mid_count();
        bus.cfg_reference = 8'd5;
        bus.cfg_arm = 1'b1;
        step();
        bus.sample_tick = 1'b1;
        step();
        bus.sample_tick = 1'b0;
        checks++;
        if (obs !== {1'b0, 2'd2, 8'd1}) begin
            failures++;
            $display("FAIL rst_pre_count got=%h exp=%h", obs, {1'b0, 2'd2, 8'd1});
        end
        rst = 1'b1;
        bus.cfg_arm = 1'b0;
        step();
        checks++;
        if (obs !== {1'b1, 2'd0, 8'd0}) begin
            failures++;
            $display("FAIL rst_mid_count got=%h exp=%h", obs, {1'b1, 2'd0, 8'd0});
        end
        rst = 1'b0;
        step();
        checks++;
        if (obs !== {1'b0, 2'd1, 8'd0}) begin
            failures++;
            $display("FAIL rst_release_idle got=%h exp=%h", obs, {1'b0, 2'd1, 8'd0});
        end
    endtask

    initial begin
        bus.cfg_enable    = 1'b0;
        bus.cfg_arm       = 1'b0;
        bus.cfg_reference = '0;
        bus.sample_tick   = 1'b0;
`ifdef COUNTER_TRIGGER_PRESCALE_EN
        bus.cfg_tick_divider = '0;
`endif
        test_reset();
        test_bypass();
        test_count_fire();
        test_ref_zero();
        test_arm_with_tick();
        test_arm_drop();
        test_disable();
        test_saturation();
`ifdef COUNTER_TRIGGER_PRESCALE_EN
        test_prescale();
`endif
        test_reset_mid_count();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
